// File: rtl/line_buf_ctrl.sv
// rtl/line_buf_ctrl.sv - one-line delay sequencer around a single-port pixel RAM with output skid FIFO.
// Optional top-border padding when LINE_BUF_CTRL_ZERO_FILL_EN is defined.
module line_buf_ctrl #(
  parameter int LINE_WORDS = 76,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_sof,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_ram_write_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_cur,
  output logic [DATA_W-1:0] o_out_prev,
  output logic              o_primed
);

`ifdef LINE_BUF_CTRL_ZERO_FILL_EN
  localparam bit ZERO_FILL = 1'b1;
`else
  localparam bit ZERO_FILL = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W:0]   FILL_DONE = (ADDR_W+1)'(LINE_WORDS);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W:0]     r_fill_cnt, w_fill_nxt;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0]   r_addr_hold;
  logic [DATA_W-1:0]   r_wr_hold;
  logic                r_in_ready;
  logic                w_accept, w_emit, w_zero;
  logic [ADDR_W-1:0]   w_addr;

  logic                r_s1_valid, r_s1_emit, r_s1_zero;
  logic [DATA_W-1:0]   r_s1_cur;

  logic [DATA_W-1:0]   r_fifo_cur  [3];
  logic [DATA_W-1:0]   r_fifo_prev [3];
  logic [1:0]          r_wr_idx, r_rd_idx, r_occ, w_occ_nxt;
  logic                w_push, w_pop;
  logic [DATA_W-1:0]   w_push_prev;

  assign w_accept       = i_in_valid & r_in_ready;
  assign w_addr         = i_in_sof ? '0 : r_ptr;
  assign o_in_ready     = r_in_ready;
  assign o_ram_write_en = w_accept;
  assign o_ram_addr     = w_accept ? w_addr : r_addr_hold;
  assign o_ram_wr_data  = w_accept ? i_in_data : r_wr_hold;
  assign o_primed       = (r_state == S_RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_FILL;
      r_fill_cnt <= '0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  // A frame start always restarts the line fill, whatever state we were in.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_ptr_nxt   = r_ptr;
    w_emit      = 1'b0;
    w_zero      = 1'b0;
    if (w_accept) begin
      if (i_in_sof) begin
        w_ptr_nxt   = ADDR_W'(1);
        w_fill_nxt  = (ADDR_W+1)'(1);
        w_state_nxt = S_FILL;
        w_emit      = ZERO_FILL;
        w_zero      = 1'b1;
      end else begin
        w_ptr_nxt = (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
        case (r_state)
          S_FILL: begin
            w_emit     = ZERO_FILL;
            w_zero     = 1'b1;
            w_fill_nxt = r_fill_cnt + 1'b1;
            if (r_fill_cnt + 1'b1 == FILL_DONE) w_state_nxt = S_RUN;
          end
          default: w_emit = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_hold <= '0;
      r_wr_hold   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_emit   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_cur    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_addr_hold <= w_addr;
        r_wr_hold   <= i_in_data;
        r_s1_emit   <= w_emit;
        r_s1_zero   <= w_zero;
        r_s1_cur    <= i_in_data;
      end
    end
  end

  assign w_push      = r_s1_valid & r_s1_emit;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_push_prev = (ZERO_FILL && r_s1_zero) ? '0 : i_ram_rd_data;

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // in_ready is computed from next-cycle occupancy so it stays a pure register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_occ      <= '0;
      r_in_ready <= 1'b1;
      for (int k = 0; k < 3; k++) begin
        r_fifo_cur[k]  <= '0;
        r_fifo_prev[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_cur[r_wr_idx]  <= r_s1_cur;
        r_fifo_prev[r_wr_idx] <= w_push_prev;
        r_wr_idx              <= (r_wr_idx == 2'd2) ? 2'd0 : r_wr_idx + 2'd1;
      end
      if (w_pop) r_rd_idx <= (r_rd_idx == 2'd2) ? 2'd0 : r_rd_idx + 2'd1;
      r_occ      <= w_occ_nxt;
      r_in_ready <= ({1'b0, w_occ_nxt} + {2'b00, w_accept}) <= 3'd2;
    end
  end

  assign o_out_valid = (r_occ != 2'd0);
  assign o_out_cur   = r_fifo_cur[r_rd_idx];
  assign o_out_prev  = r_fifo_prev[r_rd_idx];

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb/tb_line_buf_ctrl.sv - randomized self-checking bench for line_buf_ctrl against a line-history model.
module tb_line_buf_ctrl;
  localparam int LW = 76;

`ifdef LINE_BUF_CTRL_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid, i_in_sof, i_out_ready;
  logic [31:0] i_in_data;
  logic        o_in_ready, o_ram_write_en, o_out_valid, o_primed;
  logic [6:0]  o_ram_addr;
  logic [31:0] o_ram_wr_data, ram_rd, o_out_cur, o_out_prev;
  logic [31:0] mem [0:127];

  always #5 clk = ~clk;

  line_buf_ctrl #(.LINE_WORDS(LW), .ADDR_W(7), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_sof(i_in_sof), .i_in_data(i_in_data),
    .o_ram_write_en(o_ram_write_en), .o_ram_addr(o_ram_addr), .o_ram_wr_data(o_ram_wr_data),
    .i_ram_rd_data(ram_rd),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_cur(o_out_cur), .o_out_prev(o_out_prev), .o_primed(o_primed)
  );

  // Registered-read RAM returning the old contents on a write.
  always @(posedge clk) begin
    if (o_ram_write_en) mem[o_ram_addr] <= o_ram_wr_data;
    ram_rd <= mem[o_ram_addr];
  end

  typedef struct {
    logic [31:0] cur;
    logic [31:0] prev;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hist[$];
  int          checks = 0;
  int          errors = 0;
  int          tot = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          stalled = 1'b0;
  logic [31:0] last_cur, last_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    tot     = 0;
    stalled = 1'b0;
  endtask

  // One clock cycle: drive, sample at negedge, advance, update the model on acceptance.
  task automatic drive(input logic v, input logic sof, input logic [31:0] d, input logic ordy,
                       output logic acc);
    exp_t e;
    int   n;
    int   acc_cyc;
    i_in_valid  = v;
    i_in_sof    = sof;
    i_in_data   = d;
    i_out_ready = ordy;
    @(negedge clk);
    acc = v & o_in_ready;
    chk("primed", o_primed, (tot >= LW));
    if (stalled) begin
      chk("stall_valid", o_out_valid, 1);
      chk("stall_cur", o_out_cur, last_cur);
      chk("stall_prev", o_out_prev, last_prev);
    end
    if (acc) begin
      chk("wr_en", o_ram_write_en, 1);
      chk("addr", o_ram_addr, sof ? 0 : (tot % LW));
      chk("wr_data", o_ram_wr_data, d);
    end else begin
      chk("wr_en_idle", o_ram_write_en, 0);
    end
    if (ordy && o_out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", o_out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_cur", o_out_cur, e.cur);
        chk("out_prev", o_out_prev, e.prev);
        if (lat_chk) chk("latency", cyc - e.cyc, 2);
      end
    end
    stalled   = o_out_valid & ~ordy;
    last_cur  = o_out_cur;
    last_prev = o_out_prev;
    acc_cyc   = cyc;
    @(posedge clk);
    cyc++;
    if (acc) begin
      if (sof) begin
        hist.delete();
        tot = 0;
      end
      n = hist.size();
      if (n >= LW) exp_q.push_back('{cur: d, prev: hist[n-LW], cyc: acc_cyc});
      else if (ZF) exp_q.push_back('{cur: d, prev: 32'h0, cyc: acc_cyc});
      hist.push_back(d);
      if (hist.size() > LW) void'(hist.pop_front());
      tot++;
    end
    #1;
  endtask

  task automatic stream(input int words, input int start, input bit gaps, output int next);
    logic acc;
    int   i = start;
    int   guard = 0;
    logic v;
    while (i < start + words && guard < 4000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(v, 1'b0, i[31:0], 1'b1, acc);
      if (acc) i++;
      guard++;
    end
    if (guard >= 4000) chk("stream_timeout", i, start + words);
    next = i;
  endtask

  task automatic backpressure(input int start, output int next);
    logic acc;
    int   i = start;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, i[31:0], 1'b0, acc);
      if (acc) i++;
    end
    chk("bp_in_ready", o_in_ready, 0);
    chk("bp_out_valid", o_out_valid, 1);
    chk("bp_held", exp_q.size(), 3);
    next = i;
  endtask

  task automatic drain();
    logic acc;
    int   guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, acc);
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, acc);
    chk("drain_valid", o_out_valid, 0);
  endtask

  initial begin
    int   i;
    logic acc;
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_sof    = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_wr_en", o_ram_write_en, 0);
    chk("rst_addr", o_ram_addr, 0);
    chk("rst_wr_data", o_ram_wr_data, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_cur", o_out_cur, 0);
    chk("rst_out_prev", o_out_prev, 0);
    chk("rst_primed", o_primed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    stream(2 * LW, 0, 1'b0, i);
    stream(3 * LW, i, 1'b1, i);

    lat_chk = 1'b0;
    backpressure(i, i);
    drain();

    lat_chk = 1'b1;
    stream(24, i, 1'b0, i);
    drive(1'b1, 1'b1, 32'h0000_A000, 1'b1, acc);
    chk("sof_accept", acc, 1);
    stream(LW + 10, 32'h100, 1'b0, i);

    lat_chk = 1'b0;
    for (int k = 0; k < 500; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, $urandom,
            $urandom_range(0, 2) != 0, acc);
    end
    drain();

    stream(LW + 4, 32'h2000, 1'b0, i);
    backpressure(i, i);
    rst_n = 1'b0;
    i_in_valid = 1'b0;
    #1;
    chk("arst_out_valid", o_out_valid, 0);
    chk("arst_in_ready", o_in_ready, 1);
    chk("arst_addr", o_ram_addr, 0);
    chk("arst_primed", o_primed, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    stream(LW + 20, 32'h3000, 1'b0, i);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
